// File: rtl/mat_pkg.sv
// Shared definitions for the matrix tile read/write sequencers: default sizes,
// sequencer state encoding and width helpers.
package mat_pkg;
    localparam int DEF_WIDTH  = 32'sd32;
    localparam int DEF_HEIGHT = 32'sd32;
    localparam int DEF_DATA_W = 32'sd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mat_state_e;

    // Index widths never collapse to zero bits, so 1-wide dimensions still get a port.
    function automatic int clog2_min1(input int n);
        return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
    endfunction

    // Tag bundle is packed {last, eol, slice, pixel} directly above the data word.
    function automatic int tag_w(input int px_w, input int sl_w);
        return px_w + sl_w + 32'sd2;
    endfunction
endpackage

// File: rtl/mat_skid_fifo.sv
// Two-entry FIFO whose head register drives the consumer directly; the second
// entry absorbs one extra push while the head is stalled.
module mat_skid_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);
    logic         head_vld_q, head_vld_d;
    logic [W-1:0] head_q, head_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] skid_q, skid_d;
    logic         pop_s;

    assign pop_s = head_vld_q & ready_i;

    // Head refills from the skid entry first so ordering is preserved.
    always_comb begin
        head_vld_d = head_vld_q;
        head_d     = head_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (pop_s || !head_vld_q) begin
            if (skid_vld_q) begin
                head_vld_d = 1'b1;
                head_d     = skid_q;
                skid_vld_d = push_i;
                if (push_i) begin
                    skid_d = push_data_i;
                end else begin
                    skid_d = skid_q;
                end
            end else begin
                head_vld_d = push_i;
                if (push_i) begin
                    head_d = push_data_i;
                end else begin
                    head_d = head_q;
                end
            end
        end else if (!skid_vld_q) begin
            skid_vld_d = push_i;
            if (push_i) begin
                skid_d = push_data_i;
            end else begin
                skid_d = skid_q;
            end
        end else begin
            skid_vld_d = 1'b1;
        end
    end

    // Storage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_vld_q <= 1'b0;
            head_q     <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
        end else begin
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
        end
    end

    assign valid_o = head_vld_q;
    assign data_o  = head_q;
    assign count_o = {head_vld_q & skid_vld_q, head_vld_q ^ skid_vld_q};
endmodule

// File: rtl/matrix_tile_reader.sv
// Read-side sequencer: walks a WIDTH x HEIGHT matrix in RAM and streams the
// elements out with pixel/slice/eol/last tags over valid/ready.
module matrix_tile_reader #(
    parameter int WIDTH  = mat_pkg::DEF_WIDTH,
    parameter int HEIGHT = mat_pkg::DEF_HEIGHT,
    parameter int DATA_W = mat_pkg::DEF_DATA_W,
    parameter int PX_W   = mat_pkg::clog2_min1(WIDTH),
    parameter int SL_W   = mat_pkg::clog2_min1(HEIGHT),
    parameter int AD_W   = mat_pkg::clog2_min1(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [AD_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PX_W-1:0]   out_pixel,
    output logic [SL_W-1:0]   out_slice,
    output logic              out_eol,
    output logic              out_last
);
    import mat_pkg::*;

    localparam int TAG_W  = tag_w(PX_W, SL_W);
    localparam int FIFO_W = TAG_W + DATA_W;
    localparam logic [PX_W-1:0] PX_MAX = PX_W'(WIDTH - 1);
    localparam logic [SL_W-1:0] SL_MAX = SL_W'(HEIGHT - 1);

    mat_state_e        state_q, state_d;
    logic [PX_W-1:0]   px_q, px_d;
    logic [SL_W-1:0]   sl_q, sl_d;
    logic [AD_W-1:0]   addr_q, addr_d;
    logic              inflight_q;
    logic [TAG_W-1:0]  tag_q;
    logic              busy_q, done_q;
    logic              issue_s, last_s, pop_s, fifo_valid_s;
    logic [1:0]        fifo_count_s;
    logic [2:0]        occ_s;
    logic [FIFO_W-1:0] fifo_data_s;

    // Committed slots after this cycle's pop: a read may issue only while one slot is free.
    assign pop_s  = fifo_valid_s & out_ready;
    assign occ_s  = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign last_s = (px_q == PX_MAX) && (sl_q == SL_MAX);

    // Sequencer next state and index walk.
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        sl_d    = sl_q;
        addr_d  = addr_q;
        issue_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    px_d    = '0;
                    sl_d    = '0;
                    addr_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                issue_s = (occ_s < 3'd2);
                if (issue_s && last_s) begin
                    state_d = ST_DRAIN;
                    px_d    = '0;
                    sl_d    = '0;
                    addr_d  = '0;
                end else if (issue_s) begin
                    addr_d = addr_q + AD_W'(1);
                    if (px_q == PX_MAX) begin
                        px_d = '0;
                        sl_d = sl_q + SL_W'(1);
                    end else begin
                        px_d = px_q + PX_W'(1);
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: state_d = (occ_s == 3'd0) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, counters, tag pipe and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            px_q       <= '0;
            sl_q       <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            px_q       <= px_d;
            sl_q       <= sl_d;
            addr_q     <= addr_d;
            inflight_q <= issue_s;
            if (issue_s) begin
                tag_q <= {last_s, px_q == PX_MAX, sl_q, px_q};
            end
            busy_q <= (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
            done_q <= (state_d == ST_DONE);
        end
    end

    mat_skid_fifo #(
        .W(FIFO_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_data_i({tag_q, mem_rd_data}),
        .ready_i    (out_ready),
        .valid_o    (fifo_valid_s),
        .data_o     (fifo_data_s),
        .count_o    (fifo_count_s)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = issue_s;
    assign mem_addr  = addr_q;
    assign out_valid = fifo_valid_s;
    assign out_data  = fifo_data_s[DATA_W-1:0];
    assign out_pixel = fifo_data_s[DATA_W +: PX_W];
    assign out_slice = fifo_data_s[DATA_W+PX_W +: SL_W];
    assign out_eol   = fifo_data_s[DATA_W+PX_W+SL_W];
    assign out_last  = fifo_data_s[FIFO_W-1];
endmodule

// File: tb/tb_matrix_tile_reader.sv
// Bench for matrix_tile_reader: a 4x2 instance for timing, backpressure, ignored
// starts and mid-frame reset; 1x1 and 3x1 instances for the corner sizes.
`timescale 1ns/1ps
module tb_matrix_tile_reader;
    typedef struct {
        int data;
        int px;
        int sl;
        bit eol;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_m, start_c, rdy_m, rdy_c;

    logic        m_busy, m_done, m_rd_en, m_valid, m_eol, m_last;
    logic [2:0]  m_addr;
    logic [1:0]  m_px;
    logic [0:0]  m_sl;
    logic [15:0] m_rd_data, m_data;

    logic        a_busy, a_done, a_rd_en, a_valid, a_eol, a_last;
    logic [0:0]  a_addr, a_px, a_sl;
    logic [15:0] a_rd_data, a_data;

    logic        b_busy, b_done, b_rd_en, b_valid, b_eol, b_last;
    logic [1:0]  b_addr, b_px;
    logic [0:0]  b_sl;
    logic [15:0] b_rd_data, b_data;

    matrix_tile_reader #(.WIDTH(4), .HEIGHT(2), .DATA_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start_m), .busy(m_busy), .done(m_done),
        .mem_rd_en(m_rd_en), .mem_addr(m_addr), .mem_rd_data(m_rd_data),
        .out_valid(m_valid), .out_ready(rdy_m), .out_data(m_data), .out_pixel(m_px),
        .out_slice(m_sl), .out_eol(m_eol), .out_last(m_last)
    );

    matrix_tile_reader #(.WIDTH(1), .HEIGHT(1), .DATA_W(16)) u_c1 (
        .clk(clk), .rst(rst), .start(start_c), .busy(a_busy), .done(a_done),
        .mem_rd_en(a_rd_en), .mem_addr(a_addr), .mem_rd_data(a_rd_data),
        .out_valid(a_valid), .out_ready(rdy_c), .out_data(a_data), .out_pixel(a_px),
        .out_slice(a_sl), .out_eol(a_eol), .out_last(a_last)
    );

    matrix_tile_reader #(.WIDTH(3), .HEIGHT(1), .DATA_W(16)) u_c3 (
        .clk(clk), .rst(rst), .start(start_c), .busy(b_busy), .done(b_done),
        .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rd_data(b_rd_data),
        .out_valid(b_valid), .out_ready(rdy_c), .out_data(b_data), .out_pixel(b_px),
        .out_slice(b_sl), .out_eol(b_eol), .out_last(b_last)
    );

    // RAM models: RAM[i] = i + 100, one cycle read latency.
    always @(posedge clk) begin
        if (m_rd_en) m_rd_data <= 16'(m_addr) + 16'd100;
        if (a_rd_en) a_rd_data <= 16'(a_addr) + 16'd100;
        if (b_rd_en) b_rd_data <= 16'(b_addr) + 16'd100;
    end

    int n_err = 0;
    int n_chk = 0;
    int cyc_n = 0;
    int smp_cyc, t0, tc, at, snap;
    logic smp_busy, smp_done, smp_valid, smp_rd_en;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int outst[3];
    int naddr[3];
    int ndone[3];
    int dcyc[3];
    bit stall_q[3];
    logic [31:0] pdata[3];
    logic [31:0] ptag[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int d, output exp_t e, output bit ok);
        ok = 1'b0;
        e = '{default: 0};
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic int sb_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_frame(input int d, input int w, input int h);
        exp_t e;
        for (int s = 0; s < h; s++) begin
            for (int p = 0; p < w; p++) begin
                e.data = 100 + s * w + p;
                e.px   = p;
                e.sl   = s;
                e.eol  = (p == w - 1);
                e.last = (p == w - 1) && (s == h - 1);
                sb_push(d, e);
            end
        end
        naddr[d] = 0;
    endtask

    task automatic mon(input int d, input logic valid, input logic rdy,
                       input logic [31:0] data, input logic [31:0] px, input logic [31:0] sl,
                       input logic eol, input logic last, input logic rd_en,
                       input logic [31:0] addr, input logic done);
        bit pop, ok;
        exp_t e;
        logic [31:0] tagv;
        pop  = (valid === 1'b1) && (rdy === 1'b1);
        tagv = {px[13:0], sl[13:0], 2'b00, eol, last};
        if (stall_q[d]) begin
            chk($sformatf("d%0d_hold_valid", d), 32'(valid), 32'd1);
            chk($sformatf("d%0d_hold_data", d), data, pdata[d]);
            chk($sformatf("d%0d_hold_tag", d), tagv, ptag[d]);
        end
        if (rd_en === 1'b1) begin
            chk($sformatf("d%0d_issue_room", d), (outst[d] - int'(pop) < 2) ? 32'd1 : 32'd0, 32'd1);
            chk($sformatf("d%0d_rd_addr", d), addr, 32'(naddr[d]));
            naddr[d]++;
            outst[d]++;
        end
        if (pop) begin
            outst[d]--;
            sb_pop(d, e, ok);
            chk($sformatf("d%0d_sb_nonempty", d), 32'(ok), 32'd1);
            if (ok) begin
                chk($sformatf("d%0d_data", d), data, 32'(e.data));
                chk($sformatf("d%0d_pixel", d), px, 32'(e.px));
                chk($sformatf("d%0d_slice", d), sl, 32'(e.sl));
                chk($sformatf("d%0d_eol", d), 32'(eol), 32'(e.eol));
                chk($sformatf("d%0d_last", d), 32'(last), 32'(e.last));
            end
        end
        if (done === 1'b1) begin
            ndone[d]++;
            dcyc[d] = smp_cyc;
        end
        stall_q[d] = (valid === 1'b1) && (rdy !== 1'b1);
        pdata[d]   = data;
        ptag[d]    = tagv;
    endtask

    task automatic cyc();
        @(negedge clk);
        smp_cyc   = cyc_n;
        smp_busy  = m_busy;
        smp_done  = m_done;
        smp_valid = m_valid;
        smp_rd_en = m_rd_en;
        mon(0, m_valid, rdy_m, 32'(m_data), 32'(m_px), 32'(m_sl), m_eol, m_last,
            m_rd_en, 32'(m_addr), m_done);
        mon(1, a_valid, rdy_c, 32'(a_data), 32'(a_px), 32'(a_sl), a_eol, a_last,
            a_rd_en, 32'(a_addr), a_done);
        mon(2, b_valid, rdy_c, 32'(b_data), 32'(b_px), 32'(b_sl), b_eol, b_last,
            b_rd_en, 32'(b_addr), b_done);
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic start_main();
        push_frame(0, 4, 2);
        start_m = 1'b1;
        t0 = cyc_n;
        cyc();
        start_m = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle, output int when);
        bit seen;
        seen = 1'b0;
        when = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            if (toggle) rdy_m = ~rdy_m;
            cyc();
            if (smp_done === 1'b1) begin
                seen = 1'b1;
                when = smp_cyc;
            end
        end
        chk("done_within_budget", 32'(seen), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  32'(m_busy),  32'd0);
        chk({tag, "_done"},  32'(m_done),  32'd0);
        chk({tag, "_rd_en"}, 32'(m_rd_en), 32'd0);
        chk({tag, "_addr"},  32'(m_addr),  32'd0);
        chk({tag, "_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_data"},  32'(m_data),  32'd0);
        chk({tag, "_pixel"}, 32'(m_px),    32'd0);
        chk({tag, "_slice"}, 32'(m_sl),    32'd0);
        chk({tag, "_eol"},   32'(m_eol),   32'd0);
        chk({tag, "_last"},  32'(m_last),  32'd0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            outst[d] = 0; naddr[d] = 0; ndone[d] = 0; dcyc[d] = -1; stall_q[d] = 1'b0;
        end
        rst = 1'b1; start_m = 1'b0; start_c = 1'b0; rdy_m = 1'b1; rdy_c = 1'b1;
        cyc();
        cyc();
        chk_reset("reset");
        rst = 1'b0;
        cyc();

        // 1: free-running frame, cycle-exact timing
        start_main();
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("t1_busy_k%0d", k),  32'(smp_busy),  (k <= 10) ? 32'd1 : 32'd0);
            chk($sformatf("t1_valid_k%0d", k), 32'(smp_valid), (k >= 3 && k <= 10) ? 32'd1 : 32'd0);
            chk($sformatf("t1_done_k%0d", k),  32'(smp_done),  (k == 11) ? 32'd1 : 32'd0);
            chk($sformatf("t1_rd_en_k%0d", k), 32'(smp_rd_en), (k <= 8) ? 32'd1 : 32'd0);
        end
        chk("t1_sb_empty", 32'(sb_size(0)), 32'd0);
        chk("t1_done_count", 32'(ndone[0]), 32'd1);

        // 2: out_ready toggling 1-0-1-0
        rdy_m = 1'b0;
        start_main();
        wait_done(60, 1'b1, at);
        chk("t2_sb_empty", 32'(sb_size(0)), 32'd0);
        chk("t2_done_count", 32'(ndone[0]), 32'd2);
        rdy_m = 1'b1;
        cyc();

        // 3: long stall right after start
        rdy_m = 1'b0;
        start_main();
        repeat (20) cyc();
        chk("t3_reads_issued", 32'(naddr[0]), 32'd2);
        chk("t3_valid_held", 32'(m_valid), 32'd1);
        chk("t3_data_held", 32'(m_data), 32'd100);
        rdy_m = 1'b1;
        wait_done(40, 1'b0, at);
        chk("t3_sb_empty", 32'(sb_size(0)), 32'd0);
        chk("t3_done_count", 32'(ndone[0]), 32'd3);

        // 4: start while busy ignored, then back-to-back frame at done+1
        start_main();
        repeat (3) cyc();
        start_m = 1'b1;
        cyc();
        start_m = 1'b0;
        wait_done(40, 1'b0, at);
        chk("t4_done_cycle", 32'(at - t0), 32'd11);
        chk("t4_done_count", 32'(ndone[0]), 32'd4);
        start_main();
        wait_done(40, 1'b0, at);
        chk("t4_b2b_done_cycle", 32'(at - t0), 32'd11);
        chk("t4_b2b_sb_empty", 32'(sb_size(0)), 32'd0);
        chk("t4_b2b_done_count", 32'(ndone[0]), 32'd5);

        // 5: reset mid-frame, then a fresh frame
        start_main();
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_reset("t5_rst");
        q0.delete();
        outst[0] = 0;
        stall_q[0] = 1'b0;
        snap = ndone[0];
        repeat (15) cyc();
        chk("t5_no_done", 32'(ndone[0]), 32'(snap));
        chk("t5_idle_busy", 32'(m_busy), 32'd0);
        start_main();
        wait_done(40, 1'b0, at);
        chk("t5_done_cycle", 32'(at - t0), 32'd11);
        chk("t5_sb_empty", 32'(sb_size(0)), 32'd0);

        // 6: corner sizes 1x1 and 3x1
        push_frame(1, 1, 1);
        push_frame(2, 3, 1);
        start_c = 1'b1;
        tc = cyc_n;
        cyc();
        start_c = 1'b0;
        repeat (10) cyc();
        chk("t6_1x1_sb_empty", 32'(sb_size(1)), 32'd0);
        chk("t6_3x1_sb_empty", 32'(sb_size(2)), 32'd0);
        chk("t6_1x1_reads", 32'(naddr[1]), 32'd1);
        chk("t6_3x1_reads", 32'(naddr[2]), 32'd3);
        chk("t6_1x1_done_count", 32'(ndone[1]), 32'd1);
        chk("t6_3x1_done_count", 32'(ndone[2]), 32'd1);
        chk("t6_1x1_done_cycle", 32'(dcyc[1] - tc), 32'd4);
        chk("t6_3x1_done_cycle", 32'(dcyc[2] - tc), 32'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
